// File: rtl/sms32_sbox_sweep.sv
// Sweeps a combinational S-box over all 2^WIDTH inputs, streams (x,y) pairs over valid/ready
// and accumulates bijectivity, fixed-point, collision and XOR-fold statistics.
module sms32_sbox_sweep #(
   parameter int WIDTH = 6
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   output logic [WIDTH-1:0] sbox_x,
   input  logic [WIDTH-1:0] sbox_y,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_x,
   output logic [WIDTH-1:0] out_y,
   output logic             busy,
   output logic             done,
   output logic             is_perm,
   output logic [WIDTH:0]   fixed_cnt,
   output logic [WIDTH:0]   coll_cnt,
   output logic [WIDTH-1:0] y_xor
);

   localparam int DEPTH = 1 << WIDTH;

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_SWEEP = 2'd1;
   localparam logic [1:0] S_DRAIN = 2'd2;
   localparam logic [1:0] S_DONE  = 2'd3;

   logic [1:0]       state;
   logic [WIDTH-1:0] index;
   logic [DEPTH-1:0] seen;
   logic             capture;
   logic             last;
   logic             fixed_hit;
   logic             coll_hit;

   // A capture may reuse the output slot in the same cycle it is being drained.
   assign capture   = (state == S_SWEEP) && (!out_valid || out_ready);
   assign last      = (index == {WIDTH{1'b1}});
   assign fixed_hit = (sbox_y == index);
   assign coll_hit  = seen[sbox_y];

   assign sbox_x = index;
   assign busy   = (state == S_SWEEP) || (state == S_DRAIN);
   assign done   = (state == S_DONE);

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= S_IDLE;
         index     <= '0;
         seen      <= '0;
         out_valid <= 1'b0;
         out_x     <= '0;
         out_y     <= '0;
         is_perm   <= 1'b0;
         fixed_cnt <= '0;
         coll_cnt  <= '0;
         y_xor     <= '0;
      end else begin
         case (state)
            S_IDLE, S_DONE: begin
               if (start) begin
                  state     <= S_SWEEP;
                  index     <= '0;
                  seen      <= '0;
                  is_perm   <= 1'b0;
                  fixed_cnt <= '0;
                  coll_cnt  <= '0;
                  y_xor     <= '0;
               end
            end
            S_SWEEP: begin
               if (capture) begin
                  out_x         <= index;
                  out_y         <= sbox_y;
                  out_valid     <= 1'b1;
                  fixed_cnt     <= fixed_cnt + {{WIDTH{1'b0}}, fixed_hit};
                  coll_cnt      <= coll_cnt + {{WIDTH{1'b0}}, coll_hit};
                  seen[sbox_y]  <= 1'b1;
                  y_xor         <= y_xor ^ sbox_y;
                  // Index wraps to zero after the last entry; it is never reused.
                  index         <= index + WIDTH'(1);
                  if (last) begin
                     state <= S_DRAIN;
                  end
               end
            end
            S_DRAIN: begin
               if (out_valid && out_ready) begin
                  out_valid <= 1'b0;
                  is_perm   <= (coll_cnt == '0);
                  state     <= S_DONE;
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_sms32_sbox_sweep.sv
// Scoreboard bench for sms32_sbox_sweep: identity, constant and x^40 S-boxes, stall, reset, restart.
module tb_sms32_sbox_sweep;

   localparam int W = 6;

   typedef struct packed {
      logic [W-1:0] x;
      logic [W-1:0] y;
   } pair_t;

   logic         clk = 1'b0;
   logic         rst;
   logic         start;
   logic [W-1:0] sbox_x;
   logic [W-1:0] sbox_y;
   logic         out_valid;
   logic         out_ready;
   logic [W-1:0] out_x;
   logic [W-1:0] out_y;
   logic         busy;
   logic         done;
   logic         is_perm;
   logic [W:0]   fixed_cnt;
   logic [W:0]   coll_cnt;
   logic [W-1:0] y_xor;

   int    mode;
   pair_t exp_q[$];
   int    tests = 0;
   int    fails = 0;

   always #5 clk = ~clk;

   sms32_sbox_sweep #(.WIDTH(W)) dut (
      .clk       (clk),
      .rst       (rst),
      .start     (start),
      .sbox_x    (sbox_x),
      .sbox_y    (sbox_y),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_x     (out_x),
      .out_y     (out_y),
      .busy      (busy),
      .done      (done),
      .is_perm   (is_perm),
      .fixed_cnt (fixed_cnt),
      .coll_cnt  (coll_cnt),
      .y_xor     (y_xor)
   );

   // GF(2^6) with x^6 + x + 1
   function automatic logic [W-1:0] gf_mul(input logic [W-1:0] a_in, input logic [W-1:0] b);
      logic [W-1:0] a;
      logic [W-1:0] p;
      a = a_in;
      p = '0;
      for (int i = 0; i < W; i++) begin
         if (b[i]) p = p ^ a;
         if (a[W-1]) a = {a[W-2:0], 1'b0} ^ 6'b000011;
         else        a = {a[W-2:0], 1'b0};
      end
      return p;
   endfunction

   // 0: identity, 1: constant zero, 2: x^40
   function automatic logic [W-1:0] model(input int m, input logic [W-1:0] x);
      logic [W-1:0] r;
      case (m)
         0: r = x;
         1: r = '0;
         default: begin
            r = 6'd1;
            for (int i = 0; i < 40; i++) r = gf_mul(r, x);
         end
      endcase
      return r;
   endfunction

   assign sbox_y = model(mode, sbox_x);

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   always @(negedge clk) begin
      pair_t e;
      if (!rst && out_valid && out_ready) begin
         if (exp_q.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL unexpected_pair: got x=%0d y=%0d, expected no pair", out_x, out_y);
         end else begin
            e = exp_q.pop_front();
            check("pair_x", 32'(out_x), 32'(e.x));
            check("pair_y", 32'(out_y), 32'(e.y));
         end
      end
   end

   task automatic push_all(input int m);
      pair_t p;
      for (int x = 0; x < 64; x++) begin
         p.x = 6'(x);
         p.y = model(m, 6'(x));
         exp_q.push_back(p);
      end
   endtask

   task automatic run_sweep(input int m, input int stall_at, input int glitch_at,
                            input int exp_perm, input int exp_fixed, input int exp_coll,
                            input int exp_cycles);
      int           n;
      bit           stalled;
      logic [W-1:0] xv;
      mode = m;
      push_all(m);
      start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      check("start_done_clr", 32'(done), 0);
      check("start_busy", 32'(busy), 1);
      check("start_fixed_clr", 32'(fixed_cnt), 0);
      check("start_coll_clr", 32'(coll_cnt), 0);
      check("start_xor_clr", 32'(y_xor), 0);
      check("start_perm_clr", 32'(is_perm), 0);
      n = 0;
      stalled = 1'b0;
      while (!done && n < 300) begin
         @(posedge clk);
         #1;
         n++;
         start = (n == glitch_at);
         if (!stalled && stall_at >= 0 && out_valid && out_x == 6'(stall_at)) begin
            stalled = 1'b1;
            out_ready = 1'b0;
            repeat (10) @(posedge clk);
            n += 10;
            #1;
            xv = '0;
            for (int i = 0; i <= stall_at; i++) xv = xv ^ model(m, 6'(i));
            check("stall_valid", 32'(out_valid), 1);
            check("stall_x", 32'(out_x), 32'(stall_at));
            check("stall_y", 32'(out_y), 32'(model(m, 6'(stall_at))));
            check("stall_fixed", 32'(fixed_cnt), 32'(stall_at + 1));
            check("stall_coll", 32'(coll_cnt), 0);
            check("stall_xor", 32'(y_xor), 32'(xv));
            out_ready = 1'b1;
         end
      end
      start = 1'b0;
      check("done_latency", 32'(n), 32'(exp_cycles));
      check("is_perm", 32'(is_perm), 32'(exp_perm));
      check("fixed_cnt", 32'(fixed_cnt), 32'(exp_fixed));
      check("coll_cnt", 32'(coll_cnt), 32'(exp_coll));
      check("y_xor", 32'(y_xor), 0);
      check("busy_after", 32'(busy), 0);
      check("pairs_left", 32'(exp_q.size()), 0);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, expected finish");
      $fatal(1);
   end

   initial begin
      rst = 1'b1;
      start = 1'b0;
      out_ready = 1'b1;
      mode = 0;
      repeat (2) @(posedge clk);
      #1;
      check("reset_outs", {out_valid, out_x, out_y, busy, done, is_perm, fixed_cnt, coll_cnt, y_xor}, 0);
      check("reset_sbox_x", 32'(sbox_x), 0);
      rst = 1'b0;
      @(posedge clk);
      #1;

      // identity, with a stray start pulse mid-sweep
      run_sweep(0, -1, 30, 1, 64, 0, 65);
      // constant zero, started from DONE
      run_sweep(1, -1, -1, 0, 1, 63, 65);
      // x^40 power map
      run_sweep(2, -1, -1, 1, 4, 0, 65);
      // identity with a 10-cycle stall on x=5
      run_sweep(0, 5, -1, 1, 64, 0, 75);

      // abort at index 20
      mode = 0;
      push_all(0);
      start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      repeat (20) @(posedge clk);
      #1;
      check("abort_index", 32'(sbox_x), 20);
      rst = 1'b1;
      @(posedge clk);
      #1 rst = 1'b0;
      check("abort_outs", {out_valid, out_x, out_y, busy, done, is_perm, fixed_cnt, coll_cnt, y_xor}, 0);
      check("abort_sbox_x", 32'(sbox_x), 0);
      exp_q.delete();
      @(posedge clk);
      #1;
      check("abort_idle", 32'({busy, done}), 0);
      run_sweep(0, -1, -1, 1, 64, 0, 65);

      repeat (2) @(posedge clk);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
